// File: rtl/grn_pkg.sv
// grn_pkg: shared trend type and the popcount/saturating-step helpers for GRN nodes.
package grn_pkg;

    typedef enum logic [1:0] {TR_HOLD, TR_UP, TR_DOWN} trend_t;

    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int k = 0; k < 32; k++) n += 32'(v[k]);
        return n;
    endfunction

    // One-unit move toward the trend, clamped to [0, 2^w-1].
    function automatic logic [31:0] step(input logic [31:0] lv, input trend_t tr, input int unsigned w);
        logic [32:0] m;
        m = (33'd1 << w) - 33'd1;
        return (tr == TR_UP)   ? ((33'(lv) >= m) ? lv : lv + 32'd1) :
               (tr == TR_DOWN) ? ((lv == 32'd0) ? lv : lv - 32'd1) : lv;
    endfunction

endpackage

// File: rtl/grn_node_mv_if.sv
// grn_node_mv_if: control, regulator and level signals of one GRN node.
interface grn_node_mv_if #(
    parameter int WIDTH = 2,
    parameter int N_ACT = 2,
    parameter int N_INH = 1
);
    logic             reset_nos;
    logic [WIDTH-1:0] init_state;
    logic             start_s0;
    logic             start_s1;
    logic [N_ACT-1:0] act_s0;
    logic [N_INH-1:0] inh_s0;
    logic [N_ACT-1:0] act_s1;
    logic [N_INH-1:0] inh_s1;
    logic [WIDTH-1:0] s0;
    logic [WIDTH-1:0] s1;
    logic             upd_s0;
    logic             stable;

    modport master (output reset_nos, init_state, start_s0, start_s1, act_s0, inh_s0, act_s1, inh_s1,
                    input  s0, s1, upd_s0, stable);
    modport slave  (input  reset_nos, init_state, start_s0, start_s1, act_s0, inh_s0, act_s1, inh_s1,
                    output s0, s1, upd_s0, stable);
endinterface

// File: rtl/grn_trend.sv
// grn_trend: combinational consensus of activator vs inhibitor vote counts.
module grn_trend
    import grn_pkg::*;
#(
    parameter int N_ACT = 2,
    parameter int N_INH = 1
) (
    input  logic [N_ACT-1:0] i_act,
    input  logic [N_INH-1:0] i_inh,
    output trend_t           o_trend
);
    int unsigned w_a, w_i;

    always_comb begin
        w_a = popcount(32'(i_act));
        w_i = popcount(32'(i_inh));
        o_trend = (w_a > w_i) ? TR_UP : (w_a < w_i) ? TR_DOWN : TR_HOLD;
    end
endmodule

// File: rtl/grn_node_mv.sv
// grn_node_mv: multi-valued GRN node with delayed async (s0) and sync (s1) levels
// plus attractor detection on the sync channel.
module grn_node_mv
    import grn_pkg::*;
#(
    parameter int WIDTH    = 2,
    parameter int N_ACT    = 2,
    parameter int N_INH    = 1,
    parameter int DELAY    = 2,
    parameter int STABLE_N = 4
) (
    input logic clk,
    input logic rst,
    grn_node_mv_if.slave nb
);
    localparam int CW = (DELAY > 1) ? $clog2(DELAY) : 1;
    localparam int SW = $clog2(STABLE_N + 1);

    trend_t           w_t0, w_t1;
    logic [WIDTH-1:0] w_n0, w_n1;
    logic [SW-1:0]    w_sc_nxt;
    logic [WIDTH-1:0] r_s0, r_s1;
    logic [CW-1:0]    r_cnt;
    logic [SW-1:0]    r_sc;
    logic             r_upd, r_stable;

    grn_trend #(.N_ACT(N_ACT), .N_INH(N_INH)) u_t0 (.i_act(nb.act_s0), .i_inh(nb.inh_s0), .o_trend(w_t0));
    grn_trend #(.N_ACT(N_ACT), .N_INH(N_INH)) u_t1 (.i_act(nb.act_s1), .i_inh(nb.inh_s1), .o_trend(w_t1));

    always_comb begin
        w_n0 = WIDTH'(step(32'(r_s0), w_t0, WIDTH));
        w_n1 = WIDTH'(step(32'(r_s1), w_t1, WIDTH));
        w_sc_nxt = (w_n1 != r_s1) ? '0 : (r_sc == SW'(STABLE_N)) ? r_sc : r_sc + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s0     <= '0;
            r_s1     <= '0;
            r_cnt    <= CW'(DELAY - 1);
            r_sc     <= '0;
            r_upd    <= 1'b0;
            r_stable <= 1'b0;
        end else if (nb.reset_nos) begin
            r_s0     <= nb.init_state;
            r_s1     <= nb.init_state;
            r_cnt    <= '0;
            r_sc     <= '0;
            r_upd    <= 1'b0;
            r_stable <= 1'b0;
        end else begin
            r_upd <= nb.start_s0 && (r_cnt == '0);
            if (nb.start_s0) begin
                r_s0  <= (r_cnt == '0) ? w_n0 : r_s0;
                r_cnt <= (r_cnt == '0) ? CW'(DELAY - 1) : r_cnt - 1'b1;
            end
            if (nb.start_s1) begin
                r_s1     <= w_n1;
                r_sc     <= w_sc_nxt;
                r_stable <= (w_sc_nxt == SW'(STABLE_N));
            end
        end
    end

    assign nb.s0     = r_s0;
    assign nb.s1     = r_s1;
    assign nb.upd_s0 = r_upd;
    assign nb.stable = r_stable;
endmodule

// File: doc/grn_node_mv.md
# grn_node_mv

Multi-valued, parametrised gene-regulatory-network node for the GNR accelerators. Holds a WIDTH-bit expression level in two update schemes: asynchronous (s0, committed only every DELAY-th strobe) and synchronous (s1, committed every strobe). Each step moves the level one unit toward its regulators' consensus: up when activators outnumber inhibitors, down when inhibitors outnumber activators. Adds per-node attractor detection on the synchronous channel. Instantiated once per gene inside the network datapath; the network controller drives the strobes.

## Interface
Parameters:
- WIDTH, 2: state bits; MAXV = 2^WIDTH-1.
- N_ACT, 2: activator inputs per channel (>=1).
- N_INH, 1: inhibitor inputs per channel (>=1).
- DELAY, 2: s0 strobes per s0 commit (>=1).
- STABLE_N, 4: consecutive unchanged s1 steps that flag stability (>=1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- reset_nos  in  1  synchronous run re-initialise.
- init_state  in  WIDTH  level loaded on reset_nos.
- start_s0  in  1  async-scheme step strobe.
- start_s1  in  1  sync-scheme step strobe.
- act_s0  in  N_ACT  activator bits, s0 scheme.
- inh_s0  in  N_INH  inhibitor bits, s0 scheme.
- act_s1  in  N_ACT  activator bits, s1 scheme.
- inh_s1  in  N_INH  inhibitor bits, s1 scheme.
- s0  out  WIDTH  async-scheme level, registered.
- s1  out  WIDTH  sync-scheme level, registered.
- upd_s0  out  1  one-cycle pulse, s0 commit slot taken.
- stable  out  1  s1 unchanged for STABLE_N consecutive strobes.

## Operation
- Trend per channel: a = popcount(act), i = popcount(inh), unsigned. a>i gives UP, a<i gives DOWN, a==i gives HOLD.
- Step: UP gives min(level+1, MAXV); DOWN gives max(level-1, 0); HOLD keeps level. Saturating, never wraps.
- s0 slot counter cnt (0..DELAY-1):
  - On start_s0 with cnt==0: s0 <= step(s0), upd_s0 <= 1, cnt <= DELAY-1.
  - On start_s0 with cnt!=0: cnt <= cnt-1, s0 holds.
  - DELAY=1 commits on every strobe.
- s1: every start_s1 commits s1 <= step(s1).
- Stability counter sc (0..STABLE_N, saturating):
  - On start_s1: if step(s1)==s1 then sc <= min(sc+1, STABLE_N), else sc <= 0.
  - stable = (sc == STABLE_N).
- reset_nos: s0 <= init_state, s1 <= init_state, cnt <= 0 (first subsequent strobe commits), sc <= 0, upd_s0 <= 0.
- rst: s0=0, s1=0, cnt=DELAY-1 (first strobe after rst does not commit unless DELAY=1), sc=0, upd_s0=0, stable=0.
- Priority: rst > reset_nos > strobes. A strobe coinciding with reset_nos is ignored.
- start_s0 and start_s1 are independent; both may fire in the same cycle.
- Regulator inputs are sampled in the strobe cycle only.

## Timing
- All outputs registered; a commit is visible one cycle after the strobe edge.
- upd_s0 is high for exactly the cycle after a committing strobe. Back-to-back strobes with DELAY=1 hold it high continuously.
- stable asserts the cycle after the STABLE_N-th consecutive unchanged strobe. It deasserts the cycle after a changing strobe or reset_nos.
- Strobes may arrive on every cycle; no throughput restriction.
- rst deassertion is synchronised externally; an in-flight commit under rst is discarded.

## Structure
- Package grn_pkg:
  - trend_t enum {TR_HOLD, TR_UP, TR_DOWN}.
  - popcount function.
  - Saturating step function (level, trend, WIDTH).
- Sub-module grn_trend (purely combinational, parameters N_ACT/N_INH): act/inh in, trend_t out. Instantiated twice, once per channel.
- The top holds the cnt, sc and level registers.
- cnt width is max(1, clog2(DELAY)); sc width is clog2(STABLE_N+1).

## Test plan
- rst high, then low; DELAY=2, act_s0=2'b11, inh_s0=0; four start_s0 strobes -> s0: 0,1,1,2 after each; upd_s0 pulses on strobes 2 and 4 only.
- reset_nos with init_state=3, then start_s0 with act=11, inh=0 -> s0 stays 3 (saturate), upd_s0 pulses on the first strobe.
- init_state=0, act_s1=00, inh_s1=1; three start_s1 -> s1 stays 0. Fourth strobe -> stable=1 the next cycle.
- stable=1, then a start_s1 with act_s1=11 -> s1=1, stable=0 the next cycle.
- reset_nos and start_s0/start_s1 in the same cycle with init_state=2 -> s0=s1=2, cnt=0, no upd_s0 pulse.
- rst asserted mid-sequence (s0=2, s1=3, stable=1) -> all outputs 0 asynchronously. The first start_s0 afterwards (DELAY=2) does not commit.
